// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC waveform sequencer.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SAW,
        ST_TRI_UP,
        ST_TRI_DN,
        ST_SQ_HI,
        ST_SQ_LO
    } state_t;

    localparam logic [1:0] ADDR_MODE  = 2'd0;
    localparam logic [1:0] ADDR_DIV   = 2'd1;
    localparam logic [1:0] ADDR_STEP  = 2'd2;
    localparam logic [1:0] ADDR_LEVEL = 2'd3;

    localparam logic [7:0] STEP_RST  = 8'h01;
    localparam logic [7:0] LEVEL_RST = 8'h80;

    // State entered when a MODE write restarts the sequence.
    function automatic state_t entry_state(input mode_t m);
        state_t s;
        case (m)
            MODE_HOLD:   s = ST_HOLD;
            MODE_SAW:    s = ST_SAW;
            MODE_TRI:    s = ST_TRI_UP;
            MODE_SQUARE: s = ST_SQ_LO;
            default:     s = ST_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dac_seq_prescaler.sv
// Update-rate prescaler: counts 0..div_i and emits a tick on the terminal count.
module dac_seq_prescaler
    import dac_seq_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == div_i);
    assign tick_o  = en_i & ~clear_i & at_term;

    // Next count: clear wins, otherwise advance and wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_term ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_wave_sequencer.sv
// DAC code sequencer: config registers with valid/ready write port,
// prescaled update tick and the waveform state machine.
module dac_wave_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned CODE_W = 8,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_data,
    output logic [CODE_W-1:0] dac_code,
    output logic              dac_update,
    output logic              running
);

    logic              run_q,     run_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [CODE_W-1:0] step_q,    step_d;
    logic [CODE_W-1:0] level_q,   level_d;
    logic [CODE_W-1:0] code_q,    code_d;
    logic              update_q,  update_d;
    logic              ready_q,   ready_d;
    state_t            state_q,   state_d;

    logic              xfer;
    logic              pre_clear;
    logic              pre_tick;
    logic              tick;
    logic [CODE_W:0]   sum;
    mode_t             wr_mode;

    assign xfer      = cfg_valid & ready_q;
    assign wr_mode   = mode_t'(cfg_data[1:0]);
    // MODE and DIV writes restart the prescaler; run=0 keeps it parked at zero.
    assign pre_clear = ~run_q |
                       (xfer & ((cfg_addr == ADDR_MODE) | (cfg_addr == ADDR_DIV)));
    // A config transfer in the tick cycle takes priority and swallows the tick.
    assign tick      = pre_tick & ~xfer;
    assign sum       = {1'b0, code_q} + {1'b0, step_q};

    dac_seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear_i (pre_clear),
        .en_i    (run_q & enable),
        .div_i   (div_q),
        .tick_o  (pre_tick)
    );

    // Next-state: config write first, otherwise advance the waveform on a tick.
    always_comb begin
        run_d   = run_q;
        div_d   = div_q;
        step_d  = step_q;
        level_d = level_q;
        state_d = state_q;
        code_d  = code_q;
        ready_d = ~xfer;
        if (xfer) begin
            case (cfg_addr)
                ADDR_MODE: begin
                    run_d   = cfg_data[2];
                    state_d = entry_state(wr_mode);
                    code_d  = (wr_mode == MODE_HOLD) ? level_q : '0;
                end
                ADDR_DIV:   div_d   = DIV_W'(cfg_data);
                ADDR_STEP:  step_d  = CODE_W'(cfg_data);
                ADDR_LEVEL: level_d = CODE_W'(cfg_data);
                default: ;
            endcase
        end else if (tick) begin
            case (state_q)
                ST_HOLD: code_d = level_q;
                ST_SAW:  code_d = sum[CODE_W-1:0];
                ST_TRI_UP: begin
                    if (sum[CODE_W]) begin
                        code_d  = '1;
                        state_d = ST_TRI_DN;
                    end else begin
                        code_d = sum[CODE_W-1:0];
                    end
                end
                ST_TRI_DN: begin
                    if (code_q < step_q) begin
                        code_d  = '0;
                        state_d = ST_TRI_UP;
                    end else begin
                        code_d = code_q - step_q;
                    end
                end
                ST_SQ_HI: begin
                    code_d  = '0;
                    state_d = ST_SQ_LO;
                end
                ST_SQ_LO: begin
                    code_d  = level_q;
                    state_d = ST_SQ_HI;
                end
                default: state_d = ST_HOLD;
            endcase
        end
        update_d = (code_d != code_q);
    end

    // Registers and FSM state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            div_q    <= '0;
            step_q   <= CODE_W'(STEP_RST);
            level_q  <= CODE_W'(LEVEL_RST);
            code_q   <= '0;
            update_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_HOLD;
        end else begin
            run_q    <= run_d;
            div_q    <= div_d;
            step_q   <= step_d;
            level_q  <= level_d;
            code_q   <= code_d;
            update_q <= update_d;
            ready_q  <= ready_d;
            state_q  <= state_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign dac_code   = code_q;
    assign dac_update = update_q;
    assign running    = run_q & enable;

endmodule

// File: tb/tb_dac_wave_sequencer.sv
// Directed bench for dac_wave_sequencer: per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_dac_wave_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] dac_code;
    logic       dac_update;
    logic       running;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [1:0] a;
        logic [7:0] d;
        logic       en;
        logic [7:0] code;
        logic       upd;
        logic       rdy;
        logic       run;
    } vec_t;

    vec_t       tbl [24];
    logic [7:0] tri_seq [6];

    dac_wave_sequencer #(
        .CODE_W (8),
        .DIV_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .dac_code   (dac_code),
        .dac_update (dac_update),
        .running    (running)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic v, input logic [1:0] a,
                                input logic [7:0] d, input logic en, input logic [7:0] code,
                                input logic upd, input logic rdy, input logic run);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.d = d; t.en = en;
        t.code = code; t.upd = upd; t.rdy = rdy; t.run = run;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check all outputs.
    task automatic cyc(input logic rst, input logic v, input logic [1:0] a, input logic [7:0] d,
                       input logic en, input logic [7:0] ecode, input logic eupd,
                       input logic erdy, input logic erun, input string nm);
        reset     = rst;
        cfg_valid = v;
        cfg_addr  = a;
        cfg_data  = d;
        enable    = en;
        @(posedge clk);
        #1;
        chk({nm, ".code"},    dac_code,          ecode);
        chk({nm, ".update"},  {7'd0, dac_update}, {7'd0, eupd});
        chk({nm, ".ready"},   {7'd0, cfg_ready},  {7'd0, erdy});
        chk({nm, ".running"}, {7'd0, running},    {7'd0, erun});
    endtask

    task automatic idle(input logic [7:0] ecode, input logic eupd, input logic erun, input string nm);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, ecode, eupd, 1'b1, erun, nm);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;

        //            rst v  a     d      en  code   upd  rdy  run
        tbl[0]  = mk(1, 0, 2'd0, 8'h00, 1, 8'h00, 0, 1, 0);
        tbl[1]  = mk(0, 1, 2'd3, 8'h3C, 1, 8'h00, 0, 0, 0);  // LEVEL=3C
        tbl[2]  = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 0, 1, 0);
        tbl[3]  = mk(0, 1, 2'd0, 8'h00, 1, 8'h3C, 1, 0, 0);  // MODE=HOLD
        tbl[4]  = mk(0, 0, 2'd0, 8'h00, 1, 8'h3C, 0, 1, 0);
        tbl[5]  = mk(0, 1, 2'd1, 8'h00, 1, 8'h3C, 0, 0, 0);  // DIV=0
        tbl[6]  = mk(0, 0, 2'd0, 8'h00, 1, 8'h3C, 0, 1, 0);
        tbl[7]  = mk(0, 1, 2'd2, 8'h40, 1, 8'h3C, 0, 0, 0);  // STEP=40
        tbl[8]  = mk(0, 0, 2'd0, 8'h00, 1, 8'h3C, 0, 1, 0);
        tbl[9]  = mk(0, 1, 2'd0, 8'h05, 1, 8'h00, 1, 0, 1);  // MODE=SAW+run
        tbl[10] = mk(0, 0, 2'd0, 8'h00, 1, 8'h40, 1, 1, 1);
        tbl[11] = mk(0, 0, 2'd0, 8'h00, 1, 8'h80, 1, 1, 1);
        tbl[12] = mk(0, 0, 2'd0, 8'h00, 1, 8'hC0, 1, 1, 1);
        tbl[13] = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 1, 1, 1);  // modulo wrap
        tbl[14] = mk(0, 0, 2'd0, 8'h00, 1, 8'h40, 1, 1, 1);
        tbl[15] = mk(0, 1, 2'd1, 8'h03, 1, 8'h40, 0, 0, 1);  // DIV=3 on a tick: tick dropped
        tbl[16] = mk(0, 0, 2'd0, 8'h00, 1, 8'h40, 0, 1, 1);
        tbl[17] = mk(0, 1, 2'd2, 8'h60, 1, 8'h40, 0, 0, 1);  // STEP=60
        tbl[18] = mk(0, 0, 2'd0, 8'h00, 1, 8'h40, 0, 1, 1);
        tbl[19] = mk(0, 1, 2'd0, 8'h06, 1, 8'h00, 1, 0, 1);  // MODE=TRI+run on a tick
        tbl[20] = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 0, 1, 1);
        tbl[21] = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 0, 1, 1);
        tbl[22] = mk(0, 0, 2'd0, 8'h00, 1, 8'h00, 0, 1, 1);
        tbl[23] = mk(0, 0, 2'd0, 8'h00, 1, 8'h60, 1, 1, 1);

        tri_seq[0] = 8'hC0; tri_seq[1] = 8'hFF; tri_seq[2] = 8'h9F;
        tri_seq[3] = 8'h3F; tri_seq[4] = 8'h00; tri_seq[5] = 8'h60;

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].en,
                tbl[i].code, tbl[i].upd, tbl[i].rdy, tbl[i].run, $sformatf("vec%0d", i));
        end

        // Triangle continues: one code change every 4 cycles, folding at FF and 00.
        begin
            logic [7:0] prev;
            prev = 8'h60;
            for (int k = 0; k < 6; k++) begin
                for (int j = 0; j < 3; j++) idle(prev, 1'b0, 1'b1, $sformatf("tri%0d.hold%0d", k, j));
                idle(tri_seq[k], 1'b1, 1'b1, $sformatf("tri%0d.step", k));
                prev = tri_seq[k];
            end
        end

        // Reset mid-sequence with a pending MODE write: write must not land.
        cyc(1'b1, 1'b1, 2'd0, 8'h07, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "rst_mid");
        for (int j = 0; j < 3; j++) idle(8'h00, 1'b0, 1'b0, $sformatf("post_rst%0d", j));

        // cfg_valid held for four cycles: only the 1st and 3rd transfer (STEP 05 then 07).
        cyc(1'b0, 1'b1, 2'd2, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "hs0");
        cyc(1'b0, 1'b1, 2'd2, 8'h06, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "hs1");
        cyc(1'b0, 1'b1, 2'd2, 8'h07, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "hs2");
        cyc(1'b0, 1'b1, 2'd2, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, "hs3");
        // SAW with reset DIV=0; entry code unchanged so no pulse.
        cyc(1'b0, 1'b1, 2'd0, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "saw7.mode");
        idle(8'h07, 1'b1, 1'b1, "saw7.a");
        idle(8'h0E, 1'b1, 1'b1, "saw7.b");
        idle(8'h15, 1'b1, 1'b1, "saw7.c");
        // HOLD restart loads the reset LEVEL.
        cyc(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, "hold_rst_level");
        idle(8'h80, 1'b0, 1'b0, "hold_idle");

        // Square: LEVEL=AA, DIV=1.
        cyc(1'b0, 1'b1, 2'd3, 8'hAA, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, "sq.level");
        idle(8'h80, 1'b0, 1'b0, "sq.i0");
        cyc(1'b0, 1'b1, 2'd1, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, "sq.div");
        idle(8'h80, 1'b0, 1'b0, "sq.i1");
        cyc(1'b0, 1'b1, 2'd0, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, "sq.mode");
        idle(8'h00, 1'b0, 1'b1, "sq.c1");
        idle(8'hAA, 1'b1, 1'b1, "sq.c2");
        idle(8'hAA, 1'b0, 1'b1, "sq.c3");
        idle(8'h00, 1'b1, 1'b1, "sq.c4");
        for (int j = 0; j < 5; j++)
            cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, $sformatf("sq.frozen%0d", j));
        idle(8'h00, 1'b0, 1'b1, "sq.r1");
        idle(8'hAA, 1'b1, 1'b1, "sq.r2");
        idle(8'hAA, 1'b0, 1'b1, "sq.r3");
        idle(8'h00, 1'b1, 1'b1, "sq.r4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
